// File: rtl/serial_to_parallel_hs.sv
// Serial-to-parallel deserializer with qualified bits, selectable bit order,
// sof resynchronisation and a ready/valid holding register with sticky overrun.
module serial_to_parallel_hs #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  input  logic                 clear_ovr,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [N-1:0]         data_out,
  output logic                 full_tick,
  output logic                 overrun,
  output logic [$clog2(N)-1:0] bit_count
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  shift_reg;
  logic [N-1:0]  word;
  logic [CW-1:0] slot;
  logic [CW-1:0] pos;
  logic          complete;
  logic          load;
  logic          drop;

  // The incoming bit is written straight into its final position, so the
  // completed word (including the last bit) is available combinationally.
  always_comb begin
    slot      = (bit_valid && sof) ? '0 : bit_count;
    pos       = MSB_FIRST ? (LAST - slot) : slot;
    word      = shift_reg;
    word[pos] = data_in;
    complete  = bit_valid && (slot == LAST);
    load      = complete && (!m_valid || m_ready);
    drop      = complete && m_valid && !m_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      data_out  <= '0;
      m_valid   <= 1'b0;
      full_tick <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      full_tick <= complete;
      if (bit_valid) begin
        shift_reg <= word;
        bit_count <= complete ? '0 : slot + CW'(1);
      end
      if (load) begin
        data_out <= word;
        m_valid  <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // A drop on the same edge as clear_ovr leaves the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_hs.sv
// Bench for serial_to_parallel_hs: LSB-first and MSB-first instances share
// stimulus; a queue-based model is compared every cycle plus literal checks.
module tb_serial_to_parallel_hs;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sof = 1'b0;
  logic       clear_ovr = 1'b0;
  logic       m_ready = 1'b0;

  logic       l_valid, l_tick, l_ovr;
  logic [7:0] l_data;
  logic [2:0] l_count;
  logic       h_valid, h_tick, h_ovr;
  logic [7:0] h_data;
  logic [2:0] h_count;

  int compared = 0;
  int mismatched = 0;
  int tick_seen = 0;

  always #5 clk = ~clk;

  serial_to_parallel_hs #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid),
    .sof(sof), .clear_ovr(clear_ovr), .m_ready(m_ready),
    .m_valid(l_valid), .data_out(l_data), .full_tick(l_tick),
    .overrun(l_ovr), .bit_count(l_count)
  );

  serial_to_parallel_hs #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid),
    .sof(sof), .clear_ovr(clear_ovr), .m_ready(m_ready),
    .m_valid(h_valid), .data_out(h_data), .full_tick(h_tick),
    .overrun(h_ovr), .bit_count(h_count)
  );

  // Model: accepted bits of the current word live in a queue; a word is
  // built from it only once it holds eight bits.
  bit         mq[$];
  logic [7:0] m_dl = '0;
  logic [7:0] m_dm = '0;
  logic [7:0] wl, wm;
  logic       m_mv = 1'b0;
  logic       m_tick = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_done, m_drop;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_dl = '0; m_dm = '0; m_mv = 1'b0; m_tick = 1'b0; m_ovr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_drop = 1'b0;
      if (bit_valid) begin
        if (sof) mq.delete();
        mq.push_back(data_in);
        if (mq.size() == 8) begin
          for (int k = 0; k < 8; k++) begin
            wl[k]     = mq[k];
            wm[7 - k] = mq[k];
          end
          mq.delete();
          m_done = 1'b1;
        end
      end
      if (m_done) begin
        if (!m_mv || m_ready) begin
          m_dl = wl; m_dm = wm; m_mv = 1'b1;
        end else begin
          m_drop = 1'b1;
        end
      end else if (m_mv && m_ready) begin
        m_mv = 1'b0;
      end
      if (m_drop) m_ovr = 1'b1;
      else if (clear_ovr) m_ovr = 1'b0;
      m_tick = m_done;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    checkOutput("lsb_valid", 64'(l_valid), 64'(m_mv));
    checkOutput("lsb_data",  64'(l_data),  64'(m_dl));
    checkOutput("lsb_tick",  64'(l_tick),  64'(m_tick));
    checkOutput("lsb_ovr",   64'(l_ovr),   64'(m_ovr));
    checkOutput("lsb_count", 64'(l_count), 64'(mq.size()));
    checkOutput("msb_valid", 64'(h_valid), 64'(m_mv));
    checkOutput("msb_data",  64'(h_data),  64'(m_dm));
    checkOutput("msb_tick",  64'(h_tick),  64'(m_tick));
    checkOutput("msb_ovr",   64'(h_ovr),   64'(m_ovr));
    checkOutput("msb_count", 64'(h_count), 64'(mq.size()));
    if (l_tick) tick_seen++;
  end

  // One clock cycle with the given inputs; returns just after the edge.
  task automatic applyStimulus(input logic d, input logic bv, input logic s,
                               input logic clr, input logic rdy, input logic rst);
    data_in = d; bit_valid = bv; sof = s; clear_ovr = clr; m_ready = rdy; reset = rst;
    @(posedge clk);
    #1;
  endtask

  // Sends bits[first..last]; bit k of 'bits' is the k-th serial bit.
  task automatic sendBits(input logic [7:0] bits, input int first, input int last,
                          input logic gap, input logic sof_first, input logic rdy,
                          input logic rdy_last, input logic clr_last);
    for (int k = first; k <= last; k++) begin
      if (gap && k > first) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, rdy, 1'b1);
      applyStimulus(bits[k], 1'b1, sof_first && (k == first), clr_last && (k == last),
                    (k == last) ? rdy_last : rdy, 1'b1);
    end
  endtask

  initial begin
    int t0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_valid", 64'(l_valid), 64'd0);
    checkOutput("rst_data",  64'(l_data),  64'd0);
    checkOutput("rst_count", 64'(l_count), 64'd0);

    // Test 1: 0x69 LSB-first with m_ready high
    sendBits(8'h69, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_data",  64'(l_data),  64'h69);
    checkOutput("t1_msb",   64'(h_data),  64'h96);
    checkOutput("t1_valid", 64'(l_valid), 64'd1);
    checkOutput("t1_tick",  64'(l_tick),  64'd1);
    checkOutput("t1_count", 64'(l_count), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_drain", 64'(l_valid), 64'd0);
    checkOutput("t1_tick0", 64'(l_tick),  64'd0);

    // Test 2: 0,1,1,0,1,0,0,1 into the MSB-first instance, then with gaps
    sendBits(8'h96, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_msb", 64'(h_data), 64'h69);
    checkOutput("t2_lsb", 64'(l_data), 64'h96);
    sendBits(8'h96, 0, 6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_gap_count", 64'(h_count), 64'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_gap_novalid", 64'(h_valid), 64'd0);
    sendBits(8'h96, 7, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_gap_msb", 64'(h_data),  64'h69);
    checkOutput("t2_gap_tick", 64'(h_tick), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Test 3: backpressure, overrun, set-wins-over-clear, then clear
    t0 = tick_seen;
    sendBits(8'h69, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_first", 64'(l_data), 64'h69);
    checkOutput("t3_ovr0",  64'(l_ovr),  64'd0);
    sendBits(8'h0A, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_hold",  64'(l_data), 64'h69);
    checkOutput("t3_ovr1",  64'(l_ovr),  64'd1);
    checkOutput("t3_tick2", 64'(l_tick), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_ticks", 64'(tick_seen - t0), 64'd2);
    sendBits(8'h0A, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_setwins", 64'(l_ovr), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t3_xfer",  64'(l_valid), 64'd0);
    checkOutput("t3_sticky", 64'(l_ovr),  64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_clear", 64'(l_ovr), 64'd0);

    // Test 4: transfer and load on the same edge
    sendBits(8'h69, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(8'h0A, 0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_data",  64'(l_data),  64'h0A);
    checkOutput("t4_valid", 64'(l_valid), 64'd1);
    checkOutput("t4_ovr",   64'(l_ovr),   64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Test 5: sof resync, and sof on what would be the eighth bit
    t0 = tick_seen;
    sendBits(8'h07, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_partial", 64'(l_count), 64'd3);
    sendBits(8'h0A, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_sof_count", 64'(l_count), 64'd1);
    sendBits(8'h0A, 1, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_data", 64'(l_data), 64'h0A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_words", 64'(tick_seen - t0), 64'd1);
    sendBits(8'hFF, 0, 6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    sendBits(8'h69, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_nth_tick",  64'(l_tick),  64'd0);
    checkOutput("t5_nth_count", 64'(l_count), 64'd1);
    sendBits(8'h69, 1, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_nth_data", 64'(l_data), 64'h69);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Test 6: reset mid-word with a pending word and overrun set
    sendBits(8'h0A, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(8'h0A, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(8'h69, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_valid", 64'(l_valid), 64'd0);
    checkOutput("t6_data",  64'(l_data),  64'd0);
    checkOutput("t6_tick",  64'(l_tick),  64'd0);
    checkOutput("t6_ovr",   64'(l_ovr),   64'd0);
    checkOutput("t6_count", 64'(l_count), 64'd0);
    sendBits(8'h0A, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_after", 64'(l_data), 64'h0A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_hs.md
Name: serial_to_parallel_hs

Overview:
Parametrised serial-to-parallel deserializer with a qualified bit input, configurable bit order, frame resynchronisation and a ready/valid output holding register. Accumulates N serial bits into a word and presents it downstream with backpressure. Reports dropped words through a sticky overrun flag. Successor to the basic free-running deserializer; sits between a bit-level receiver and word-level consumers.

Parameters:
N, 8, word width in bits; legal range 2..64.
MSB_FIRST, 0, 0: first received bit lands in data_out[0]; 1: first received bit lands in data_out[N-1].

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
data_in  input  1  serial data bit.
bit_valid  input  1  data_in is sampled only on cycles where this is high.
sof  input  1  start of frame; qualified by bit_valid.
clear_ovr  input  1  clears the sticky overrun flag.
m_ready  input  1  downstream ready.
m_valid  output  1  data_out holds an unconsumed word.
data_out  output  N  assembled word; stable while m_valid=1 and m_ready=0.
full_tick  output  1  one-cycle pulse on each word completion, including dropped words.
overrun  output  1  sticky; a completed word was dropped.
bit_count  output  $clog2(N)  bits accepted in the current partial word.

Behaviour:
- Reset (reset=0 at a clock edge) sets all outputs to 0: m_valid, data_out, full_tick, overrun and bit_count. It also clears the shift register. It overrides every other input, and a partial word in flight is discarded.
- Bit accept: a bit is taken on an edge with bit_valid=1. Cycles with bit_valid=0 leave the shift register and bit_count unchanged, so gaps are allowed anywhere.
- Bit order, LSB-first (MSB_FIRST=0): the k-th accepted bit of a word (k=0..N-1) ends up in data_out[k].
- Bit order, MSB-first (MSB_FIRST=1): the k-th accepted bit ends up in data_out[N-1-k].
- Counting: bit_count increments on each accepted bit. On the N-th bit it wraps to 0, and that edge is the completion edge.
- On the completion edge: full_tick=1 for exactly the following cycle, and the assembled word (including the N-th bit) is offered to the holding register.
- Latency: data_out and m_valid update at the completion edge. A word is visible in the cycle immediately after its last bit is presented.
- sof: when bit_valid=1 and sof=1, the partial word is discarded and the current bit is treated as bit 0 of a new word. Afterwards bit_count=1 (or, for N=... wraps as usual). sof with bit_valid=0 is ignored.
- sof with N-th bit: if sof is asserted on what would have been the N-th bit, no word completes and no full_tick fires.
- Handshake: a transfer occurs on an edge where m_valid=1 and m_ready=1. After the transfer, m_valid drops to 0 unless a new word loads on the same edge.
- Holding-register load rules at the completion edge:
  - m_valid=0: load, then m_valid=1.
  - m_valid=1 and m_ready=1 on the same edge: transfer the old word and load the new one; m_valid stays 1; no overrun.
  - m_valid=1 and m_ready=0: the new word is dropped, data_out is unchanged, and overrun sets to 1. full_tick still pulses.
- Overrun: once set, it stays 1 until an edge with clear_ovr=1. If a drop and clear_ovr=1 occur on the same edge, overrun ends at 1 (set wins).
- m_ready with no data: m_ready is ignored while m_valid=0.
- State: one counter, one shift register, one holding register plus valid bit, and the overrun flag. No multi-cycle stall; a bit is accepted on every cycle that has bit_valid=1.

Test Plan:
1. N=8, MSB_FIRST=0, m_ready=1: release reset, then drive 0x69 LSB-first (1,0,0,1,0,1,1,0) on 8 consecutive cycles. Expect data_out=0x69, m_valid=1 and full_tick=1 in the cycle after the 8th bit; m_valid falls the next cycle; bit_count returns to 0.
2. MSB_FIRST=1: drive bits 0,1,1,0,1,0,0,1. Expect data_out=0x69. Repeat the bits with bit_valid low on alternate cycles; expect the same word, 8 accepted bits later.
3. Backpressure, m_ready=0: send 0x69 then 0x0A back to back. Expect data_out to stay 0x69, overrun=1, and two full_tick pulses. Then assert m_ready=1 for one cycle, so m_valid→0. Then assert clear_ovr, so overrun→0.
4. Simultaneous transfer and load: hold m_ready=1 while 0x0A completes with 0x69 pending. Expect 0x69 to transfer, data_out=0x0A, m_valid to stay 1, and overrun=0.
5. sof resync: send 3 bits, then assert sof with the first bit of 0x0A and continue with 0x0A. Expect exactly one word, 0x0A, with no word formed from the first 3 bits.
6. Reset mid-word: after 5 bits of 0x69, assert reset=0 for one cycle. Expect all outputs 0. A subsequent full 0x0A frame yields data_out=0x0A.
